// File: rtl/cr_huf_comp_st_lut_seq.sv
// Sequences the STCL then ST LUT fill for one Huffman block: accepts code
// lengths from the tree-walker and issues registered, one-cycle-latency LUT writes.
module cr_huf_comp_st_lut_seq #(
    parameter int STCL_DEPTH = 19,
    parameter int ST_DEPTH   = 576,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 5,
    parameter int MAX_LEN    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seq_start,
    input  logic [4:0]        stcl_num,
    input  logic [ADDR_W-1:0] st_num,
    input  logic              seq_abort,
    input  logic              tw_len_vld,
    input  logic [LEN_W-1:0]  tw_len,
    output logic              tw_len_rdy,
    output logic              stcl_lut_wr,
    output logic              st_lut_wr,
    output logic [ADDR_W-1:0] lut_wr_addr,
    output logic [LEN_W-1:0]  lut_wr_data,
    output logic              st_stcl_lut_wr_done,
    output logic              st_st_lut_wr_done,
    output logic              seq_busy,
    output logic              len_err,
    output logic [ADDR_W-1:0] used_syms
);

    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STCL_WR = 2'd1,
        ST_WR   = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] stcl_num_reg, stcl_num_next;
    logic [ADDR_W-1:0] st_num_reg, st_num_next;
    logic [ADDR_W-1:0] addr_cnt_reg, addr_cnt_next;
    logic              stcl_wr_reg, stcl_wr_next;
    logic              st_wr_reg, st_wr_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [LEN_W-1:0]  wr_data_reg, wr_data_next;
    logic              stcl_done_reg, stcl_done_next;
    logic              st_done_reg, st_done_next;
    logic              len_err_reg, len_err_next;
    logic [ADDR_W-1:0] used_syms_reg, used_syms_next;

    logic [ADDR_W-1:0] stcl_num_cap;
    logic [ADDR_W-1:0] st_num_cap;
    logic              abort_hit;
    logic              len_rdy;
    logic              accept;
    logic              len_bad;
    logic [LEN_W-1:0]  len_sat;

    // Counts beyond the LUT depth are clamped so the address never runs past the table.
    assign stcl_num_cap = (int'(stcl_num) > STCL_DEPTH) ? ADDR_W'(STCL_DEPTH) : ADDR_W'(stcl_num);
    assign st_num_cap   = (int'(st_num) > ST_DEPTH) ? ADDR_W'(ST_DEPTH) : st_num;

    // Per-phase end-of-table detection; index 0 is STCL, index 1 is ST.
    logic [ADDR_W-1:0] phase_num [2];
    logic [1:0]        phase_last;
    logic [1:0]        phase_empty;

    assign phase_num[0] = stcl_num_reg;
    assign phase_num[1] = st_num_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_phase
            assign phase_last[gi]  = (addr_cnt_reg == (phase_num[gi] - ADDR_ONE));
            assign phase_empty[gi] = (phase_num[gi] == '0);
        end
    endgenerate

    assign abort_hit = seq_abort && (state_reg != IDLE);
    // Abort masks ready so nothing is accepted in the abort cycle.
    assign len_rdy   = !abort_hit &&
                       ((state_reg == STCL_WR) || ((state_reg == ST_WR) && !phase_empty[1]));
    assign accept    = tw_len_vld && len_rdy;
    assign len_bad   = (tw_len > LEN_MAX);
    assign len_sat   = len_bad ? LEN_MAX : tw_len;

    always_comb begin
        state_next     = state_reg;
        stcl_num_next  = stcl_num_reg;
        st_num_next    = st_num_reg;
        addr_cnt_next  = addr_cnt_reg;
        stcl_wr_next   = 1'b0;
        st_wr_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        stcl_done_next = 1'b0;
        st_done_next   = 1'b0;
        len_err_next   = len_err_reg;
        used_syms_next = used_syms_reg;

        case (state_reg)
            IDLE: begin
                if (seq_start) begin
                    stcl_num_next  = stcl_num_cap;
                    st_num_next    = st_num_cap;
                    addr_cnt_next  = '0;
                    len_err_next   = 1'b0;
                    used_syms_next = '0;
                    if (stcl_num_cap == '0) begin
                        stcl_done_next = 1'b1;
                        if (st_num_cap == '0) begin
                            st_done_next = 1'b1;
                            state_next   = IDLE;
                        end else begin
                            state_next = ST_WR;
                        end
                    end else begin
                        state_next = STCL_WR;
                    end
                end
            end

            STCL_WR: begin
                if (accept) begin
                    stcl_wr_next = 1'b1;
                    wr_addr_next = addr_cnt_reg;
                    wr_data_next = len_sat;
                    if (len_bad) begin
                        len_err_next = 1'b1;
                    end
                    if (phase_last[0]) begin
                        addr_cnt_next  = '0;
                        stcl_done_next = 1'b1;
                        state_next     = ST_WR;
                    end else begin
                        addr_cnt_next = addr_cnt_reg + ADDR_ONE;
                    end
                end
            end

            ST_WR: begin
                if (phase_empty[1]) begin
                    st_done_next = 1'b1;
                    state_next   = FLUSH;
                end else if (accept) begin
                    st_wr_next   = 1'b1;
                    wr_addr_next = addr_cnt_reg;
                    wr_data_next = len_sat;
                    if (len_bad) begin
                        len_err_next = 1'b1;
                    end
                    if (tw_len != '0) begin
                        used_syms_next = used_syms_reg + ADDR_ONE;
                    end
                    if (phase_last[1]) begin
                        addr_cnt_next = '0;
                        st_done_next  = 1'b1;
                        state_next    = FLUSH;
                    end else begin
                        addr_cnt_next = addr_cnt_reg + ADDR_ONE;
                    end
                end
            end

            FLUSH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A write already registered still drains; no done pulse may follow an abort.
        if (abort_hit) begin
            state_next     = IDLE;
            addr_cnt_next  = '0;
            stcl_done_next = 1'b0;
            st_done_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            stcl_num_reg  <= '0;
            st_num_reg    <= '0;
            addr_cnt_reg  <= '0;
            stcl_wr_reg   <= 1'b0;
            st_wr_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            stcl_done_reg <= 1'b0;
            st_done_reg   <= 1'b0;
            len_err_reg   <= 1'b0;
            used_syms_reg <= '0;
        end else begin
            state_reg     <= state_next;
            stcl_num_reg  <= stcl_num_next;
            st_num_reg    <= st_num_next;
            addr_cnt_reg  <= addr_cnt_next;
            stcl_wr_reg   <= stcl_wr_next;
            st_wr_reg     <= st_wr_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            stcl_done_reg <= stcl_done_next;
            st_done_reg   <= st_done_next;
            len_err_reg   <= len_err_next;
            used_syms_reg <= used_syms_next;
        end
    end

    assign tw_len_rdy          = len_rdy;
    assign stcl_lut_wr         = stcl_wr_reg;
    assign st_lut_wr           = st_wr_reg;
    assign lut_wr_addr         = wr_addr_reg;
    assign lut_wr_data         = wr_data_reg;
    assign st_stcl_lut_wr_done = stcl_done_reg;
    assign st_st_lut_wr_done   = st_done_reg;
    assign seq_busy            = (state_reg != IDLE);
    assign len_err             = len_err_reg;
    assign used_syms           = used_syms_reg;

endmodule

// File: tb/tb_cr_huf_comp_st_lut_seq.sv
// Bench for cr_huf_comp_st_lut_seq: table-driven blocks plus abort/reset sequences,
// with a write scoreboard filled on each accept and drained on each LUT write.
module tb_cr_huf_comp_st_lut_seq;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              seq_start;
    logic [4:0]        stcl_num;
    logic [ADDR_W-1:0] st_num;
    logic              seq_abort;
    logic              tw_len_vld;
    logic [LEN_W-1:0]  tw_len;
    logic              tw_len_rdy;
    logic              stcl_lut_wr;
    logic              st_lut_wr;
    logic [ADDR_W-1:0] lut_wr_addr;
    logic [LEN_W-1:0]  lut_wr_data;
    logic              st_stcl_lut_wr_done;
    logic              st_st_lut_wr_done;
    logic              seq_busy;
    logic              len_err;
    logic [ADDR_W-1:0] used_syms;

    always #5 clk = ~clk;

    cr_huf_comp_st_lut_seq #(
        .STCL_DEPTH(19), .ST_DEPTH(576), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_LEN(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seq_start(seq_start), .stcl_num(stcl_num),
        .st_num(st_num), .seq_abort(seq_abort), .tw_len_vld(tw_len_vld),
        .tw_len(tw_len), .tw_len_rdy(tw_len_rdy), .stcl_lut_wr(stcl_lut_wr),
        .st_lut_wr(st_lut_wr), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .st_stcl_lut_wr_done(st_stcl_lut_wr_done), .st_st_lut_wr_done(st_st_lut_wr_done),
        .seq_busy(seq_busy), .len_err(len_err), .used_syms(used_syms)
    );

    typedef struct {
        int stcl_n;
        int st_n;
        bit throttle;
        int mode;
        int exp_stcl_wr;
        int exp_st_wr;
        int exp_used;
        int exp_err;
        int exp_span;
    } vec_t;

    typedef struct {
        bit st;
        int addr;
        int data;
        bit done;
        int cyc;
    } wr_exp_t;

    vec_t    vecs [7];
    wr_exp_t wr_q [$];
    wr_exp_t wr_e;
    wr_exp_t wr_p;
    int      thr_lens [7] = '{3, 0, 4, 2, 5, 0, 7};

    int checks = 0;
    int fails  = 0;
    int cyc_cnt = 0;
    int n_stcl_wr, n_st_wr, stcl_done_cnt, st_done_cnt, first_wr, last_wr;
    int m_phase, m_idx, m_stcl_n, m_st_n;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endfunction

    function automatic int len_for(int mode, int k, int stcl_n);
        case (mode)
            1:       return thr_lens[k % 7];
            2:       return (k == stcl_n + 3) ? 20 : (k % 15) + 1;
            3:       return k % 3;
            default: return (k % 15) + 1;
        endcase
    endfunction

    // Scoreboard: drain on each strobe, then push the write implied by this cycle's accept.
    task automatic monitor_step();
        cyc_cnt++;
        if (st_stcl_lut_wr_done) stcl_done_cnt++;
        if (st_st_lut_wr_done) st_done_cnt++;
        if (stcl_lut_wr || st_lut_wr) begin
            if (stcl_lut_wr) n_stcl_wr++;
            if (st_lut_wr) n_st_wr++;
            if (first_wr < 0) first_wr = cyc_cnt;
            last_wr = cyc_cnt;
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                wr_p = wr_q.pop_front();
                check("wr_phase_st", int'(st_lut_wr), int'(wr_p.st));
                check("wr_phase_stcl", int'(stcl_lut_wr), int'(!wr_p.st));
                check("wr_addr", int'(lut_wr_addr), wr_p.addr);
                check("wr_data", int'(lut_wr_data), wr_p.data);
                check("wr_latency", cyc_cnt - wr_p.cyc, 1);
                check("wr_done", wr_p.st ? int'(st_st_lut_wr_done) : int'(st_stcl_lut_wr_done),
                      int'(wr_p.done));
            end
        end
        if (rst_n && tw_len_vld && tw_len_rdy) begin
            wr_e.st   = (m_phase != 0);
            wr_e.addr = m_idx;
            wr_e.data = (int'(tw_len) > 15) ? 15 : int'(tw_len);
            wr_e.cyc  = cyc_cnt;
            wr_e.done = (m_phase == 0) ? (m_idx == m_stcl_n - 1) : (m_idx == m_st_n - 1);
            wr_q.push_back(wr_e);
            if (m_phase == 0 && m_idx == m_stcl_n - 1) begin
                m_phase = 1;
                m_idx   = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    // Called at posedge+1 with the DUT idle; leaves the bench at posedge+1 after the start edge.
    task automatic start_block(input int s1, input int s2, input bit abort_at_start);
        wr_q.delete();
        n_stcl_wr = 0; n_st_wr = 0; stcl_done_cnt = 0; st_done_cnt = 0;
        first_wr = -1; last_wr = -1;
        m_phase = (s1 == 0) ? 1 : 0; m_idx = 0; m_stcl_n = s1; m_st_n = s2;
        seq_start = 1'b1;
        seq_abort = abort_at_start;
        stcl_num  = 5'(s1);
        st_num    = ADDR_W'(s2);
        @(posedge clk); #1;
        seq_start = 1'b0;
        seq_abort = 1'b0;
    endtask

    task automatic feed(input int total, input bit throttle, input int mode, input int stcl_n,
                        output int k);
        int cyc;
        cyc = 0;
        k = 0;
        while (k < total && cyc < 2000) begin
            tw_len_vld = throttle ? (cyc % 2 == 0) : 1'b1;
            tw_len     = LEN_W'(len_for(mode, k, stcl_n));
            @(negedge clk);
            if (tw_len_vld && tw_len_rdy) k++;
            @(posedge clk); #1;
            cyc++;
        end
        tw_len_vld = 1'b0;
    endtask

    task automatic run_vec(input int idx, input bit abort_at_start);
        vec_t v;
        int   k;
        int   span;
        v = vecs[idx];
        start_block(v.stcl_n, v.st_n, abort_at_start);
        @(negedge clk);
        check("start_stcl_done", int'(st_stcl_lut_wr_done), int'(v.stcl_n == 0));
        check("start_st_done", int'(st_st_lut_wr_done), int'(v.stcl_n == 0 && v.st_n == 0));
        check("start_busy", int'(seq_busy), int'(!(v.stcl_n == 0 && v.st_n == 0)));
        check("start_len_err", int'(len_err), 0);
        check("start_used", int'(used_syms), 0);
        @(posedge clk); #1;
        feed(v.stcl_n + v.st_n, v.throttle, v.mode, v.stcl_n, k);
        repeat (4) @(negedge clk);
        span = (first_wr < 0) ? 0 : last_wr - first_wr + 1;
        check("accepts", k, v.stcl_n + v.st_n);
        check("stcl_wr_count", n_stcl_wr, v.exp_stcl_wr);
        check("st_wr_count", n_st_wr, v.exp_st_wr);
        check("stcl_done_count", stcl_done_cnt, 1);
        check("st_done_count", st_done_cnt, 1);
        check("used_syms", int'(used_syms), v.exp_used);
        check("len_err", int'(len_err), v.exp_err);
        check("end_busy", int'(seq_busy), 0);
        check("sb_empty", wr_q.size(), 0);
        check("write_span", span, v.exp_span);
        $display("vec %0d: stcl=%0d st=%0d writes=%0d/%0d used=%0d len_err=%0d span=%0d",
                 idx, v.stcl_n, v.st_n, n_stcl_wr, n_st_wr, used_syms, len_err, span);
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"}, int'(tw_len_rdy), 0);
        check({tag, "_stcl_wr"}, int'(stcl_lut_wr), 0);
        check({tag, "_st_wr"}, int'(st_lut_wr), 0);
        check({tag, "_addr"}, int'(lut_wr_addr), 0);
        check({tag, "_data"}, int'(lut_wr_data), 0);
        check({tag, "_stcl_done"}, int'(st_stcl_lut_wr_done), 0);
        check({tag, "_st_done"}, int'(st_st_lut_wr_done), 0);
        check({tag, "_busy"}, int'(seq_busy), 0);
        check({tag, "_len_err"}, int'(len_err), 0);
        check({tag, "_used"}, int'(used_syms), 0);
    endtask

    initial begin
        int k;
        //          stcl  st thr mode  wS   wT  used err span
        vecs[0] = '{19, 286, 1'b0, 0, 19, 286, 286, 0, 305};
        vecs[1] = '{ 4,   3, 1'b1, 1,  4,   3,   2, 0,  13};
        vecs[2] = '{ 0,   5, 1'b0, 0,  0,   5,   5, 0,   5};
        vecs[3] = '{ 0,   0, 1'b0, 0,  0,   0,   0, 0,   0};
        vecs[4] = '{ 2,   6, 1'b0, 2,  2,   6,   6, 1,   8};
        vecs[5] = '{ 5,   9, 1'b0, 3,  5,   9,   6, 0,  14};
        vecs[6] = '{ 3,   0, 1'b0, 0,  3,   0,   0, 0,   3};

        rst_n = 1'b0; seq_start = 1'b0; stcl_num = '0; st_num = '0;
        seq_abort = 1'b0; tw_len_vld = 1'b0; tw_len = '0;
        first_wr = -1; last_wr = -1;
        m_phase = 0; m_idx = 0; m_stcl_n = 0; m_st_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, 1'b0);
        end

        // Abort after 10 ST accepts; a held seq_start with other counts must be ignored.
        start_block(2, 40, 1'b0);
        seq_start = 1'b1; stcl_num = 5'd7; st_num = ADDR_W'(3);
        feed(12, 1'b0, 0, 2, k);
        check("abort_accepts", k, 12);
        seq_start = 1'b0; seq_abort = 1'b1; tw_len_vld = 1'b1; tw_len = 5'd4;
        @(negedge clk);
        check("abort_rdy", int'(tw_len_rdy), 0);
        check("abort_last_wr", int'(st_lut_wr), 1);
        check("abort_last_addr", int'(lut_wr_addr), 9);
        check("abort_st_done", int'(st_st_lut_wr_done), 0);
        @(posedge clk); #1;
        seq_abort = 1'b0; tw_len_vld = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(seq_busy), 0);
        repeat (3) @(negedge clk);
        check("abort_st_wr_count", n_st_wr, 10);
        check("abort_st_done_count", st_done_cnt, 0);
        check("abort_stcl_done_count", stcl_done_cnt, 1);
        check("abort_sb_empty", wr_q.size(), 0);
        $display("abort: st writes=%0d st_done=%0d busy=%0d", n_st_wr, st_done_cnt, seq_busy);
        @(posedge clk); #1;

        // Restart after abort, with seq_abort high in the idle start cycle.
        run_vec(5, 1'b1);

        // Reset in the middle of STCL_WR with seq_start held high.
        start_block(19, 5, 1'b0);
        feed(6, 1'b0, 0, 19, k);
        rst_n = 1'b0; seq_start = 1'b1; stcl_num = 5'd4; st_num = ADDR_W'(4);
        @(negedge clk);
        @(negedge clk);
        check_quiet("rst_mid");
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_hold_busy", int'(seq_busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; seq_start = 1'b0;
        @(negedge clk);
        check("rst_release_busy", int'(seq_busy), 0);
        check("rst_stcl_wr_count", n_stcl_wr, 6);
        check("rst_sb_empty", wr_q.size(), 0);
        $display("reset: stcl writes before reset=%0d busy=%0d", n_stcl_wr, seq_busy);
        @(posedge clk); #1;

        run_vec(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
